// File: rtl/ma216_audio_pkg.sv
// rtl/ma216_audio_pkg.sv - shared PCM type, audio constants and 16-bit saturation helpers for the MA216 audio output stage
package ma216_audio_pkg;

  typedef logic signed [15:0] pcm16_t;

  // Board audio is unsigned 8-bit with silence at mid-scale.
  localparam int AUDIO_MIDSCALE = 128;

  localparam int PCM_MAX = 32767;
  localparam int PCM_MIN = -32768;

  // Clamp a wide signed value into the signed 16-bit PCM range.
  function automatic pcm16_t sat16(input logic signed [31:0] v);
    if (v > PCM_MAX) begin
      return pcm16_t'(PCM_MAX);
    end else if (v < PCM_MIN) begin
      return pcm16_t'(PCM_MIN);
    end else begin
      return pcm16_t'(v);
    end
  endfunction

  // True when sat16 would have to clamp the value.
  function automatic logic sat16_clips(input logic signed [31:0] v);
    return (v > PCM_MAX) || (v < PCM_MIN);
  endfunction

endpackage

// File: rtl/ma216_audio_out_lpf.sv
// rtl/ma216_audio_out_lpf.sv - ma216_onepole_lpf: oversampled one-pole IIR low-pass, alpha = 2^-FILT_SHIFT
module ma216_onepole_lpf
  import ma216_audio_pkg::*;
#(
  parameter int FILT_SHIFT = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic signed [15:0] x,
  output logic signed [15:0] y
);

  // Accumulator holds y scaled by 2^FILT_SHIFT; its steady state is x << FILT_SHIFT,
  // which always fits in 16+FILT_SHIFT signed bits.
  localparam int AW = 16 + FILT_SHIFT;

  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] acc_next;
  logic signed [AW-1:0] x_ext;
  logic signed [AW-1:0] leak;

  // Next accumulator value: add the new input, leak out 2^-FILT_SHIFT of the history.
  // The sum may wrap transiently at AW bits but the final result is always in range,
  // so modular arithmetic yields the exact answer.
  always_comb begin
    x_ext    = AW'(x);
    leak     = acc >>> FILT_SHIFT;
    acc_next = acc + x_ext - leak;
  end

  // Filter history register, cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc <= '0;
    end else begin
      acc <= acc_next;
    end
  end

  // Filter output is the arithmetic shift of the accumulator (floor division).
  assign y = acc[AW-1:FILT_SHIFT];

endmodule

// File: rtl/ma216_audio_out.sv
// rtl/ma216_audio_out.sv - MA216 audio output stage: filter, decimate, valid/ready PCM; DC blocker under MA216_AUDIO_DCBLOCK_EN
module ma216_audio_out
  import ma216_audio_pkg::*;
#(
  parameter int SAMPLE_DIV = 112,
  parameter int FILT_SHIFT = 3,
  parameter int DC_SHIFT   = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         audio_in,
  input  logic               mute,
  output logic signed [15:0] sample,
  output logic               sample_valid,
  input  logic               sample_ready,
  output logic               overrun,
  output logic               clip
);

  localparam bit PARAMS_LEGAL = (SAMPLE_DIV >= 2) && (SAMPLE_DIV <= 65535) &&
                                (FILT_SHIFT >= 1) && (FILT_SHIFT <= 8) &&
                                (DC_SHIFT >= 1) && (DC_SHIFT <= 16);

  // Out-of-range settings elaborate this empty, easily spotted scope in the hierarchy.
  if (!PARAMS_LEGAL) begin : g_illegal_parameters
  end

  pcm16_t      x;
  pcm16_t      y;
  pcm16_t      y_out;
  logic [15:0] count;
  logic        tick;

  // Re-centre the unsigned board audio around zero and scale it to full 16-bit range.
  always_comb begin
    x = pcm16_t'((int'(audio_in) - AUDIO_MIDSCALE) * 256);
  end

  ma216_onepole_lpf #(
    .FILT_SHIFT(FILT_SHIFT)
  ) u_lpf (
    .clk  (clk),
    .reset(reset),
    .x    (x),
    .y    (y)
  );

  assign tick = (count == 16'(SAMPLE_DIV - 1));

  // Decimation divider: one tick every SAMPLE_DIV cycles, first tick SAMPLE_DIV cycles after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (tick) begin
      count <= '0;
    end else begin
      count <= count + 16'd1;
    end
  end

`ifdef MA216_AUDIO_DCBLOCK_EN
  // dc carries 16 integer bits plus DC_SHIFT fraction bits.
  localparam int DW = 16 + DC_SHIFT;

  logic signed [DW-1:0] dc;
  logic signed [DW:0]   dc_err;
  logic signed [16:0]   y_corr;
  logic                 sat_hit;

  // Remove the tracked DC level and saturate back into PCM range.
  always_comb begin
    dc_err  = ((DW+1)'(y) <<< DC_SHIFT) - (DW+1)'(dc);
    y_corr  = 17'(y) - 17'($signed(dc[DW-1:DC_SHIFT]));
    y_out   = sat16(32'(y_corr));
    sat_hit = sat16_clips(32'(y_corr));
  end

  // DC tracker moves 2^-DC_SHIFT of the way toward the filtered level on each tick;
  // clip records any saturation seen on a tick until reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      dc   <= '0;
      clip <= 1'b0;
    end else if (tick) begin
      dc <= dc + DW'(dc_err >>> DC_SHIFT);
      if (sat_hit) begin
        clip <= 1'b1;
      end
    end
  end
`else
  // Without the DC blocker the filtered value passes straight through and cannot clip.
  always_comb begin
    y_out = y;
  end

  assign clip = 1'b0;
`endif

  // Output register and handshake: a tick always loads (the filter output from before this
  // cycle's accumulator update), overwriting an unaccepted sample flags a sticky overrun,
  // and an accepted sample without a tick retires sample_valid while holding the value.
  always_ff @(posedge clk) begin
    if (reset) begin
      sample       <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
    end else if (tick) begin
      sample       <= mute ? '0 : y_out;
      sample_valid <= 1'b1;
      if (sample_valid && !sample_ready) begin
        overrun <= 1'b1;
      end
    end else if (sample_valid && sample_ready) begin
      sample_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ma216_audio_out.sv
// tb/tb_ma216_audio_out.sv - scoreboard bench for ma216_audio_out against a cycle-level reference model
module tb_ma216_audio_out;

  localparam int DIV = 112;
  localparam int FS  = 3;

  logic               clk          = 1'b0;
  logic               reset        = 1'b1;
  logic [7:0]         audio_in     = 8'd128;
  logic               mute         = 1'b0;
  logic               sample_ready = 1'b0;
  logic signed [15:0] sample;
  logic               sample_valid;
  logic               overrun;
  logic               clip;

  always #5 clk = ~clk;

  ma216_audio_out #(
    .SAMPLE_DIV(DIV),
    .FILT_SHIFT(FS),
    .DC_SHIFT  (10)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .audio_in    (audio_in),
    .mute        (mute),
    .sample      (sample),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .overrun     (overrun),
    .clip        (clip)
  );

  typedef struct {
    bit v;
    bit o;
    int s;
  } st_t;

  st_t status_q[$];
  int  xfer_q[$];

  int tests = 0;
  int fails = 0;

  // Reference model state: filter history (scaled by 2^FS), edges since reset release,
  // and the output register as the consumer sees it.
  int m_acc    = 0;
  int m_cyc    = 0;
  int m_sample = 0;
  bit m_valid  = 1'b0;
  bit m_over   = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model by one clock edge with the inputs currently driven.
  task automatic model_step();
    int  xin;
    int  yf;
    st_t st;
    if (reset) begin
      m_acc    = 0;
      m_cyc    = 0;
      m_valid  = 1'b0;
      m_sample = 0;
      m_over   = 1'b0;
    end else begin
      xin   = (int'(audio_in) - 128) * 256;
      yf    = m_acc >>> FS;
      m_cyc = m_cyc + 1;
      if (m_valid && sample_ready) xfer_q.push_back(m_sample);
      if (m_cyc % DIV == 0) begin
        if (m_valid && !sample_ready) m_over = 1'b1;
        m_sample = mute ? 0 : yf;
        m_valid  = 1'b1;
      end else if (m_valid && sample_ready) begin
        m_valid = 1'b0;
      end
      m_acc = m_acc + xin - yf;
    end
    st.v = m_valid;
    st.o = m_over;
    st.s = m_sample;
    status_q.push_back(st);
  endtask

  // One clock: drive on the falling edge, predict, then return just after the rising edge.
  task automatic cycle(input int a, input bit r, input bit m, input bit rst);
    @(negedge clk);
    audio_in     = 8'(a);
    sample_ready = r;
    mute         = m;
    reset        = rst;
    model_step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: checks every completed transfer against the scoreboard and the visible state per edge.
  initial begin
    bit  pv;
    int  ps;
    int  exp_x;
    st_t st;
    pv = 1'b0;
    ps = 0;
    forever begin
      @(posedge clk);
      #1;
      if (pv && sample_ready && !reset) begin
        if (xfer_q.size() == 0) begin
          check("xfer_unexpected", 1, 0);
        end else begin
          exp_x = xfer_q.pop_front();
          check("xfer_sample", ps, exp_x);
        end
      end
      if (status_q.size() != 0) begin
        st = status_q.pop_front();
        check("sample_valid", int'(sample_valid), int'(st.v));
        check("overrun", int'(overrun), int'(st.o));
        check("sample", int'(sample), st.s);
        check("clip", int'(clip), 0);
      end
      pv = sample_valid;
      ps = int'(sample);
    end
  end

  initial begin
    int n;
    int prev;
    int a;
    bit r;
    bit m;
    bit rst;
    int rp;

    cycle(128, 1, 0, 1);
    cycle(128, 1, 0, 1);
    check("reset_valid", int'(sample_valid), 0);
    check("reset_sample", int'(sample), 0);
    check("reset_overrun", int'(overrun), 0);
    check("reset_clip", int'(clip), 0);

    // Silence: first valid DIV cycles after release, then one pulse per DIV cycles.
    n = 0;
    do begin
      cycle(128, 1, 0, 0);
      n++;
    end while (!sample_valid && n < 300);
    check("first_valid_latency", n, DIV);
    n = 0;
    for (int i = 0; i < 10 * DIV; i++) begin
      cycle(128, 1, 0, 0);
      if (sample_valid) n++;
    end
    check("valid_pulses", n, 10);

    // Positive full-scale step, then negative full-scale.
    prev = -40000;
    for (int i = 0; i < 3 * DIV; i++) begin
      cycle(255, 1, 0, 0);
      if (sample_valid) begin
        check("rise_monotonic", (int'(sample) >= prev) ? 1 : 0, 1);
        prev = int'(sample);
      end
    end
    check("rise_final", prev, 32512);
    prev = 40000;
    for (int i = 0; i < 3 * DIV; i++) begin
      cycle(0, 1, 0, 0);
      if (sample_valid) begin
        check("fall_monotonic", (int'(sample) <= prev) ? 1 : 0, 1);
        prev = int'(sample);
      end
    end
    check("fall_final", prev, -32768);

    // Reset while a sample is pending.
    n = 0;
    do begin
      cycle(0, 0, 0, 0);
      n++;
    end while (!sample_valid && n < 300);
    check("pending_before_reset", int'(sample_valid), 1);
    cycle(0, 0, 0, 1);
    check("midreset_valid", int'(sample_valid), 0);
    check("midreset_sample", int'(sample), 0);
    check("midreset_overrun", int'(overrun), 0);
    n = 0;
    do begin
      cycle(0, 0, 0, 0);
      n++;
    end while (!sample_valid && n < 300);
    check("post_reset_latency", n, DIV);

    // Overrun: a second tick with the consumer stalled.
    for (int i = 0; i < DIV; i++) cycle(0, 0, 0, 0);
    check("overrun_set", int'(overrun), 1);
    check("overrun_valid", int'(sample_valid), 1);
    for (int i = 0; i < 20; i++) cycle(0, 0, 0, 0);
    cycle(0, 1, 0, 0);
    check("overrun_drain_valid", int'(sample_valid), 0);
    check("overrun_sticky", int'(overrun), 1);

    // Tick coincident with an accepted transfer.
    cycle(128, 0, 0, 1);
    for (int i = 1; i < 2 * DIV; i++) cycle(255, 0, 0, 0);
    cycle(255, 1, 0, 0);
    check("coincident_valid", int'(sample_valid), 1);
    check("coincident_overrun", int'(overrun), 0);
    check("coincident_sample", int'(sample), 32512);
    cycle(255, 1, 0, 0);
    check("coincident_drain", int'(sample_valid), 0);

    // Mute keeps the filter running; releasing it yields full scale at once.
    for (int i = 0; i < 2 * DIV; i++) begin
      cycle(255, 1, 1, 0);
      if (sample_valid) check("muted_sample", int'(sample), 0);
    end
    n = 0;
    do begin
      cycle(255, 1, 0, 0);
      n++;
    end while (!sample_valid && n < 300);
    check("unmute_sample", int'(sample), 32512);

    // Randomised traffic: held levels, varying consumer duty, occasional mute and reset.
    a  = 128;
    m  = 1'b0;
    rp = 75;
    for (int i = 0; i < 4000; i++) begin
      if (i % 500 == 0) rp = int'($urandom_range(0, 100));
      if ($urandom_range(0, 19) == 0) a = int'($urandom_range(0, 255));
      r   = (int'($urandom_range(0, 99)) < rp);
      if ($urandom_range(0, 299) == 0) m = !m;
      rst = ($urandom_range(0, 999) == 0);
      cycle(a, r, m, rst);
    end

    #2;
    check("xfer_queue_drained", xfer_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ma216_audio_out.md
Name: ma216_audio_out

Overview:
- Downstream stage of the MA216 sound board.
- Consumes the board's 8-bit unsigned mixed audio (DAC latch plus Votrax mix) sampled every clk.
- Applies an oversampled one-pole low-pass filter to model the analogue output stage, then decimates to a fixed output rate.
- Delivers signed 16-bit PCM samples to the top-level audio path over a valid/ready handshake.

Parameters:
- SAMPLE_DIV, 112, clk cycles per output sample; legal range 2..65535.
- FILT_SHIFT, 3, IIR coefficient exponent (alpha = 2^-FILT_SHIFT); legal range 1..8.
- DC_SHIFT, 10, DC-tracker time-constant exponent; used only with the optional feature.

Ports:
- clk, input, 1: sound board clock.
- reset, input, 1: synchronous, active-high.
- audio_in, input, 8: unsigned board audio; 128 is silence.
- mute, input, 1: forces emitted samples to 0; the filter keeps running.
- sample, output, 16: signed PCM sample.
- sample_valid, output, 1: a sample is pending.
- sample_ready, input, 1: consumer accepts the sample.
- overrun, output, 1: sticky; a pending sample was overwritten.
- clip, output, 1: sticky; saturation occurred (optional feature only, else tied 0).

Behaviour:
- Clocking: single clock clk. Reset is synchronous and active-high. All state updates on posedge clk.
- Reset values:
  - divider count 0; accumulator 0
  - sample 16'h0000; sample_valid 0; overrun 0; clip 0
  - DC estimate 0
- Input conversion, every cycle: x = (audio_in - 128) << 8, signed 16-bit.
  - audio_in=0 gives -32768; 128 gives 0; 255 gives 32512.
- Filter, every cycle:
  - acc is signed, 16+FILT_SHIFT bits. acc <= acc + x - (acc >>> FILT_SHIFT).
  - y = acc >>> FILT_SHIFT, using arithmetic shift.
  - Steady state y = x. No overflow is possible by construction, so no saturation is needed here.
- Divider:
  - count increments each cycle and wraps from SAMPLE_DIV-1 to 0.
  - tick is asserted in the cycle where count == SAMPLE_DIV-1.
  - The first tick occurs SAMPLE_DIV cycles after reset deasserts.
- Output load on tick:
  - sample <= mute ? 0 : y_out, where y_out is y, or the DC-corrected value with the optional feature.
  - sample_valid <= 1.
  - The load uses the y value from before that cycle's accumulator update, giving 1-cycle filter-to-output latency.
- Handshake:
  - Transfer occurs when sample_valid && sample_ready at a clock edge.
  - Without tick: sample_valid <= 0 after transfer; sample holds its last value.
  - tick in the same cycle as a transfer: the new sample loads, sample_valid stays 1, overrun is unchanged.
  - tick while sample_valid=1 and sample_ready=0: the sample is overwritten and overrun <= 1 (sticky until reset).
  - sample_ready is ignored while sample_valid=0.
  - sample is stable while sample_valid=1 and no tick occurs.
- Reset mid-operation: any pending sample is dropped, sample_valid drops on the next edge, and the filter history is cleared.
- Widths: all intermediate arithmetic is signed. The final output is truncated to 16 bits only after saturation (optional feature) or is guaranteed in range (base).

Optional Feature:
- Macro: MA216_AUDIO_DCBLOCK_EN.
- With the macro defined:
  - On each tick, dc <= dc + ((y - dc) >>> DC_SHIFT), where dc is signed, 16+DC_SHIFT bits of fraction, and its integer part is used.
  - y_out = sat16(y - dc).
  - If saturation engages, clip <= 1 (sticky).
- Without the macro: y_out = y, and clip is constant 0.

Decomposition:
- Package ma216_audio_pkg holds:
  - typedef pcm16_t (signed 16-bit);
  - localparam AUDIO_MIDSCALE = 128;
  - a sat16 function;
  - the constants PCM_MAX = 32767 and PCM_MIN = -32768.
- One sub-module, ma216_onepole_lpf, contains the accumulator and shift parameterised by FILT_SHIFT. The top module holds the divider, handshake, mute and optional DC block.

Test Plan:
1. Hold audio_in=128, sample_ready=1 for 1000 cycles -> every sample=0. sample_valid pulses exactly once per 112 cycles; the first pulse is visible 112 cycles after reset release.
2. Step audio_in 128->255 with FILT_SHIFT=3 -> samples rise monotonically and reach 32512 within 200 cycles. With audio_in=0 they converge to -32768. There is never any wrap.
3. sample_ready=0 across two ticks -> sample updates to the second value, overrun=1 and remains 1. Raising sample_ready clears sample_valid after one edge.
4. tick coincident with a ready transfer -> sample_valid stays 1 with the new value, overrun=0.
5. mute=1 while audio_in=255 -> samples are 0. Releasing mute gives a full-scale sample immediately (the filter was running).
6. Assert reset for 1 cycle mid-stream with sample_valid=1 -> sample_valid=0, sample=0 and overrun=0 after the edge. The next valid arrives 112 cycles later.
   - With MA216_AUDIO_DCBLOCK_EN, a constant audio_in=200 decays toward 0, and clip stays 0.
